// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 3-digit seven-segment display by watching its segment and strobe lines.
// Each digit must settle, then decode to the same value MATCH times in a row, before it is accepted.
module seg7_scan_reader #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned MATCH   = 2,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [2:0]  dig,
  output logic [11:0] digits,
  output logic [2:0]  dvalid,
  output logic [2:0]  bad,
  output logic        upd,
  output logic        lost
);

  localparam logic [3:0]  SettleW   = 4'(SETTLE);
  localparam logic [2:0]  MatchW    = 3'(MATCH);
  localparam logic [15:0] TimeoutW  = 16'(TIMEOUT);
  localparam logic [15:0] TimeoutM1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StHold} state_e;

  function automatic logic is_onehot(logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  function automatic logic [1:0] strobe_idx(logic [2:0] v);
    if (v[2]) return 2'd2;
    if (v[1]) return 2'd1;
    return 2'd0;
  endfunction

  // Returns {good, code}; anything not in the font is reported as not good.
  function automatic logic [4:0] decode(logic [6:0] s);
    case (s)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h58: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  logic [6:0]  seg_meta_q, sseg_q;
  logic [2:0]  dig_meta_q, sdig_q;
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  cap_dig_q;
  logic        samp_vld_q;
  logic [6:0]  samp_seg_q;
  logic [1:0]  samp_idx_q;
  logic        dec_vld_q, dec_good_q;
  logic [3:0]  dec_code_q;
  logic [1:0]  dec_idx_q;
  logic [3:0]  d_q    [3];
  logic [3:0]  cand_q [3];
  logic [2:0]  match_q[3];
  logic [2:0]  dvalid_q, bad_q;
  logic        upd_q, lost_q;
  logic [15:0] idle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_meta_q <= '0;
      sseg_q     <= '0;
      dig_meta_q <= '0;
      sdig_q     <= '0;
    end else begin
      seg_meta_q <= seg;
      sseg_q     <= seg_meta_q;
      dig_meta_q <= dig;
      sdig_q     <= dig_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cap_dig_q  <= '0;
      samp_vld_q <= 1'b0;
      samp_seg_q <= '0;
      samp_idx_q <= '0;
    end else begin
      samp_vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (is_onehot(sdig_q)) begin
            state_q   <= StSettle;
            cnt_q     <= 4'd1;
            cap_dig_q <= sdig_q;
          end
        end
        StSettle: begin
          // cap_dig_q is one-hot, so any difference also covers zero/multi-hot
          if (sdig_q != cap_dig_q) state_q <= StIdle;
          else if (cnt_q >= SettleW) state_q <= StSample;
          else cnt_q <= cnt_q + 4'd1;
        end
        StSample: begin
          samp_seg_q <= sseg_q;
          samp_idx_q <= strobe_idx(cap_dig_q);
          samp_vld_q <= 1'b1;
          state_q    <= StHold;
        end
        StHold: begin
          if (sdig_q != cap_dig_q) begin
            if (is_onehot(sdig_q)) begin
              state_q   <= StSettle;
              cnt_q     <= 4'd1;
              cap_dig_q <= sdig_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_vld_q  <= 1'b0;
      dec_good_q <= 1'b0;
      dec_code_q <= '0;
      dec_idx_q  <= '0;
    end else begin
      dec_vld_q                <= samp_vld_q;
      {dec_good_q, dec_code_q} <= decode(samp_seg_q);
      dec_idx_q                <= samp_idx_q;
    end
  end

  logic [3:0] cur_cand, cur_d;
  logic [2:0] cur_match, match_nxt;
  logic       cur_dv, confirm, accept, timeout_hit;

  always_comb begin
    cur_cand  = '0;
    cur_d     = '0;
    cur_match = '0;
    cur_dv    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dec_idx_q == 2'(i)) begin
        cur_cand  = cand_q[i];
        cur_d     = d_q[i];
        cur_match = match_q[i];
        cur_dv    = dvalid_q[i];
      end
    end
    if (dec_code_q == cur_cand) match_nxt = (cur_match >= MatchW) ? cur_match : cur_match + 3'd1;
    else match_nxt = 3'd1;
    confirm     = match_nxt >= MatchW;
    accept      = confirm && (!cur_dv || (cur_d != dec_code_q));
    timeout_hit = (state_q != StSample) && (idle_q == TimeoutM1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        d_q[i]     <= '0;
        cand_q[i]  <= '0;
        match_q[i] <= '0;
      end
      dvalid_q <= '0;
      bad_q    <= '0;
      upd_q    <= 1'b0;
      lost_q   <= 1'b0;
      idle_q   <= '0;
    end else begin
      upd_q <= 1'b0;
      if (state_q == StSample) begin
        idle_q <= '0;
        lost_q <= 1'b0;
      end else if (idle_q != TimeoutW) begin
        idle_q <= idle_q + 16'd1;
      end
      if (dec_vld_q) begin
        for (int i = 0; i < 3; i++) begin
          if (dec_idx_q == 2'(i)) begin
            if (dec_good_q) begin
              cand_q[i]  <= dec_code_q;
              match_q[i] <= match_nxt;
              if (confirm) bad_q[i] <= 1'b0;
              if (accept) begin
                d_q[i]      <= dec_code_q;
                dvalid_q[i] <= 1'b1;
                upd_q       <= 1'b1;
              end
            end else begin
              bad_q[i]   <= 1'b1;
              match_q[i] <= '0;
            end
          end
        end
      end
      // Scan loss wins over a same-cycle acceptance.
      if (timeout_hit) begin
        lost_q   <= 1'b1;
        dvalid_q <= '0;
        for (int i = 0; i < 3; i++) match_q[i] <= '0;
        if (|dvalid_q) upd_q <= 1'b1;
      end
    end
  end

  assign digits = {d_q[2], d_q[1], d_q[0]};
  assign dvalid = dvalid_q;
  assign bad    = bad_q;
  assign upd    = upd_q;
  assign lost   = lost_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: scan-table vectors plus hand sequences; every upd pulse is
// checked against a queue of expected snapshots produced by a small reference model.
module tb_seg7_scan_reader;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned MATCH   = 2;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [2:0]  dig;
  logic [11:0] digits;
  logic [2:0]  dvalid, bad;
  logic        upd, lost;

  always #5 clk = ~clk;

  seg7_scan_reader #(.SETTLE(SETTLE), .MATCH(MATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .dig   (dig),
    .digits(digits),
    .dvalid(dvalid),
    .bad   (bad),
    .upd   (upd),
    .lost  (lost)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    logic [11:0] digits;
    logic [2:0]  dvalid;
  } snap_t;
  snap_t exp_q[$];

  // Reference model of the per-digit acceptance rules.
  logic [6:0] lut   [16];
  logic [3:0] m_d   [3];
  logic [3:0] m_cand[3];
  int         m_match[3];
  logic [2:0] m_dv, m_bad;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_d[i] = '0; m_cand[i] = '0; m_match[i] = 0;
    end
    m_dv = '0; m_bad = '0;
  endtask

  task automatic model_sample(input int i, input logic [6:0] s);
    int code = -1;
    snap_t sn;
    for (int k = 0; k < 16; k++) if (lut[k] == s) code = k;
    if (code < 0) begin
      m_bad[i] = 1'b1;
      m_match[i] = 0;
    end else begin
      if (4'(code) == m_cand[i]) begin
        if (m_match[i] < int'(MATCH)) m_match[i]++;
      end else begin
        m_cand[i] = 4'(code);
        m_match[i] = 1;
      end
      if (m_match[i] >= int'(MATCH)) begin
        m_bad[i] = 1'b0;
        if (!m_dv[i] || m_d[i] != 4'(code)) begin
          m_d[i] = 4'(code);
          m_dv[i] = 1'b1;
          sn.digits = {m_d[2], m_d[1], m_d[0]};
          sn.dvalid = m_dv;
          exp_q.push_back(sn);
        end
      end
    end
  endtask

  // Each upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL upd_unexpected: got upd=1 digits=%0h dvalid=%b, required no pulse at %0t",
                 digits, dvalid, $time);
      end else begin
        snap_t s;
        s = exp_q.pop_front();
        check("upd_digits", 32'(digits), 32'(s.digits));
        check("upd_dvalid", 32'(dvalid), 32'(s.dvalid));
      end
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic strobe(input int i, input logic [6:0] s, input int len, input bit modeled);
    dig = 3'(1 << i);
    seg = s;
    if (modeled) model_sample(i, s);
    repeat (len) @(negedge clk);
  endtask

  task automatic gap(input int n);
    dig = 3'b000;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    strobe(0, s0, 8, 1'b1);
    strobe(1, s1, 8, 1'b1);
    strobe(2, s2, 8, 1'b1);
    gap(4);
  endtask

  typedef struct {
    logic [6:0]  s0, s1, s2;
    logic [11:0] e_digits;
    logic [2:0]  e_dv, e_bad;
  } vec_t;
  vec_t tbl[9];

  initial begin
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};
    tbl[0] = '{7'h06, 7'h5B, 7'h4F, 12'h000, 3'b000, 3'b000};
    tbl[1] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 3'b111, 3'b000};
    tbl[2] = '{7'h66, 7'h5B, 7'h4F, 12'h321, 3'b111, 3'b000};
    tbl[3] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 3'b111, 3'b000};
    tbl[4] = '{7'h06, 7'h00, 7'h4F, 12'h321, 3'b111, 3'b010};
    tbl[5] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 3'b111, 3'b010};
    tbl[6] = '{7'h06, 7'h5B, 7'h4F, 12'h321, 3'b111, 3'b000};
    tbl[7] = '{7'h7F, 7'h77, 7'h71, 12'h321, 3'b111, 3'b000};
    tbl[8] = '{7'h7F, 7'h77, 7'h71, 12'hFA8, 3'b111, 3'b000};

    model_reset();
    rst = 1'b1;
    dig = 3'b000;
    seg = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits), 32'h000);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_bad", 32'(bad), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_lost", 32'(lost), 32'h0);
    rst = 1'b0;
    gap(2);

    for (int r = 0; r < 9; r++) begin
      run_scan(tbl[r].s0, tbl[r].s1, tbl[r].s2);
      check($sformatf("row%0d_digits", r), 32'(digits), 32'(tbl[r].e_digits));
      check($sformatf("row%0d_dvalid", r), 32'(dvalid), 32'(tbl[r].e_dv));
      check($sformatf("row%0d_bad", r), 32'(bad), 32'(tbl[r].e_bad));
      check($sformatf("row%0d_lost", r), 32'(lost), 32'h0);
      check($sformatf("row%0d_pending_upd", r), 32'(exp_q.size()), 32'h0);
    end

    // Short strobes and a multi-hot strobe must never be sampled.
    strobe(0, 7'h3F, 3, 1'b0);
    gap(3);
    strobe(0, 7'h3F, 3, 1'b0);
    gap(3);
    dig = 3'b011;
    seg = 7'h3F;
    repeat (8) @(negedge clk);
    gap(4);
    check("short_digits", 32'(digits), 32'hFA8);
    check("short_dvalid", 32'(dvalid), 32'h7);
    check("short_lost", 32'(lost), 32'h0);

    // Scan loss: one upd pulse with all dvalid cleared, digits retained.
    begin
      snap_t sn;
      sn.digits = 12'hFA8;
      sn.dvalid = 3'b000;
      exp_q.push_back(sn);
      m_dv = '0;
      for (int i = 0; i < 3; i++) m_match[i] = 0;
    end
    for (int k = 0; k < 150 && lost !== 1'b1; k++) @(negedge clk);
    check("timeout_lost", 32'(lost), 32'h1);
    @(negedge clk);
    check("timeout_dvalid", 32'(dvalid), 32'h0);
    check("timeout_digits", 32'(digits), 32'hFA8);
    check("timeout_pending_upd", 32'(exp_q.size()), 32'h0);

    // Resume: lost clears on the first sample, values reacquired after two scans.
    strobe(0, 7'h06, 8, 1'b1);
    check("resume_lost", 32'(lost), 32'h0);
    strobe(1, 7'h5B, 8, 1'b1);
    strobe(2, 7'h4F, 8, 1'b1);
    gap(4);
    check("resume1_dvalid", 32'(dvalid), 32'h0);
    run_scan(7'h06, 7'h5B, 7'h4F);
    check("resume2_digits", 32'(digits), 32'h321);
    check("resume2_dvalid", 32'(dvalid), 32'h7);
    check("resume2_pending_upd", 32'(exp_q.size()), 32'h0);

    // Prime d0 with candidate 4, then reset during HOLD of the confirming strobe.
    run_scan(7'h66, 7'h5B, 7'h4F);
    dig = 3'b001;
    seg = 7'h66;
    for (int k = 0; k < 40 && dut.state_q != 2'd3; k++) @(negedge clk);
    check("hold_reached", 32'(dut.state_q), 32'h3);
    rst = 1'b1;
    dig = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    check("hold_rst_digits", 32'(digits), 32'h000);
    check("hold_rst_dvalid", 32'(dvalid), 32'h0);
    check("hold_rst_bad", 32'(bad), 32'h0);
    check("hold_rst_upd", 32'(upd), 32'h0);
    check("hold_rst_lost", 32'(lost), 32'h0);
    repeat (6) @(negedge clk);
    check("post_rst_digits", 32'(digits), 32'h000);
    check("post_rst_dvalid", 32'(dvalid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
